// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: bus read issue, response pairing and instruction buffer
// Reads are throttled so buffered plus in-flight instructions never exceed DEPTH.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);
  localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic [PW-1:0] b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic [31:0]   a_mem_q  [DEPTH];
  logic [31:0]   b_inst_q [DEPTH];
  logic [31:0]   b_addr_q [DEPTH];
  logic [CW:0]   inflight;
  logic          grant, rsp, keep, pop;

  // Outstanding count includes reads that will be discarded, keeping the bus bounded.
  assign inflight     = {1'b0, cnt_q} + {1'b0, out_q};
  assign ibus_req_o   = !rst && !jump_en_i && (inflight < (CW+1)'(DEPTH));
  assign ibus_addr_o  = pc_q;
  assign inst_valid_o = (cnt_q != '0);
  assign inst_o       = inst_valid_o ? b_inst_q[b_rd_q] : NOP;
  assign inst_addr_o  = inst_valid_o ? b_addr_q[b_rd_q] : 32'h0;

  assign grant = ibus_req_o && ibus_gnt_i;
  assign rsp   = ibus_rvalid_i && (out_q != '0);
  assign keep  = rsp && !jump_en_i && (disc_q == '0);
  assign pop   = inst_valid_o && inst_ready_i;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(grant) - CW'(rsp);
    disc_d = disc_q;
    cnt_d  = cnt_q + CW'(keep) - CW'(pop);
    a_wr_d = a_wr_q;
    a_rd_d = a_rd_q;
    b_wr_d = b_wr_q;
    b_rd_d = b_rd_q;
    if (grant) begin
      pc_d   = pc_q + 32'd4;
      a_wr_d = a_wr_q + PW'(1);
    end
    if (rsp && !jump_en_i && (disc_q != '0)) disc_d = disc_q - CW'(1);
    if (keep) begin
      a_rd_d = a_rd_q + PW'(1);
      b_wr_d = b_wr_q + PW'(1);
    end
    if (pop) b_rd_d = b_rd_q + PW'(1);
    // A redirect flushes everything; whatever is still on the bus must be dropped.
    if (jump_en_i) begin
      pc_d   = {jump_addr_i[31:2], 2'b00};
      disc_d = out_d;
      cnt_d  = '0;
      a_wr_d = '0;
      a_rd_d = '0;
      b_wr_d = '0;
      b_rd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= {RESET_PC[31:2], 2'b00};
      out_q  <= '0;
      disc_q <= '0;
      cnt_q  <= '0;
      a_wr_q <= '0;
      a_rd_q <= '0;
      b_wr_q <= '0;
      b_rd_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      a_wr_q <= a_wr_d;
      a_rd_q <= a_rd_d;
      b_wr_q <= b_wr_d;
      b_rd_q <= b_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) a_mem_q[a_wr_q] <= pc_q;
    if (keep) begin
      b_inst_q[b_wr_q] <= ibus_rdata_i;
      b_addr_q[b_wr_q] <= a_mem_q[a_rd_q];
    end
  end
endmodule
